hdc_ctrl_profiler: RTL and testbench
====================================

HDC_CTRL_PROFILER -- requirements
Module: hdc_ctrl_profiler

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, number of monitored ap_ctrl channels (legal 1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of every counter and of rd_data (legal 16..64).
REQ-003 SHALL have port ap_clk, input, 1, single clock; all logic is rising-edge.
REQ-004 SHALL have port ap_rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port prof_en, input, 1, counting enable; when low, all counters and FSMs hold.
REQ-006 SHALL have port prof_clear, input, 1, synchronous clear of all counters, flags and FSMs.
REQ-007 SHALL have port ch_start, input, NUM_CH, per-channel ap_start.
REQ-008 SHALL have port ch_done, input, NUM_CH, per-channel ap_done.
REQ-009 SHALL have port ch_continue, input, NUM_CH, per-channel ap_continue; tie high for non-dataflow modules.
REQ-010 SHALL have port ch_blk, input, NUM_CH, per-channel stall indicator (state_blk / block_subdone).
REQ-011 SHALL have port rd_req, input, 1, readout request pulse.
REQ-012 SHALL have port rd_ch, input, 4, channel index to read.
REQ-013 SHALL have port rd_sel, input, 3, counter select.
REQ-014 SHALL have port rd_valid, output, 1, readout data valid.
REQ-015 SHALL have port rd_data, output, CNT_W, readout data.
REQ-016 SHALL have port any_busy, output, 1, OR of all channel BUSY/WAIT_CONT states.

Function
REQ-017 Each channel SHALL run an FSM with states IDLE, BUSY and WAIT_CONT.
REQ-018 IDLE->BUSY SHALL occur on ch_start=1; txn_count +1 and latency accumulator loads 1.
REQ-019 IDLE with ch_start=1 and ch_done=1 in the same cycle SHALL count a 1-cycle transaction and go to IDLE or WAIT_CONT per ch_continue.
REQ-020 In BUSY, each cycle SHALL increment busy_cycles and the latency accumulator, and SHALL increment stall_cycles when ch_blk=1; ch_start is ignored.
REQ-021 BUSY with ch_done=1 SHALL latch last_lat = accumulator, then go to IDLE if ch_continue=1, else WAIT_CONT.
REQ-022 WAIT_CONT SHALL increment wait_cycles each cycle and go to IDLE when ch_continue=1.
REQ-023 ch_done in IDLE without ch_start SHALL be ignored and SHALL set sticky flag spurious_done.
REQ-024 All counters SHALL saturate at 2^CNT_W-1 (no wrap) and set sticky flag ovf.
REQ-025 rd_sel encoding SHALL be: 0 txn_count, 1 busy_cycles, 2 stall_cycles, 3 wait_cycles, 4 last_lat, 5 max_lat, 6 status {state[1:0], ovf, spurious_done} zero-extended, 7 zero.
REQ-026 rd_valid SHALL pulse exactly 1 cycle after rd_req, with rd_data sampled from counter values at the rd_req edge; rd_data SHALL be 0 when rd_valid=0.
REQ-027 rd_ch >= NUM_CH SHALL return rd_valid=1 with rd_data=0.
REQ-028 prof_clear SHALL take priority over counting in the same cycle; rd_req concurrent with prof_clear SHALL return pre-clear values.
REQ-029 prof_en=0 mid-transaction SHALL freeze the FSM; on re-enable, counting resumes without losing state.

Reset
REQ-030 Assertion of ap_rst_n=0 SHALL immediately force all FSMs to IDLE, all counters and flags to 0, and rd_valid, rd_data and any_busy to 0, including mid-transaction.
REQ-031 The first active cycle after deassertion SHALL be able to accept ch_start.

Configuration
REQ-032 With macro HDC_PROF_MAX_LAT_EN defined, max_lat SHALL track the largest last_lat since reset or clear.
REQ-033 Without HDC_PROF_MAX_LAT_EN, max_lat storage SHALL be absent and rd_sel=5 SHALL return 0.

Verification
REQ-034 Verification SHALL cover: ch0 start at t0, done at t0+9, continue=1 -> txn_count=1, busy_cycles=10, last_lat=10.
REQ-035 Verification SHALL cover: ch2 blk high 4 of 12 busy cycles -> stall_cycles=4, busy_cycles=12.
REQ-036 Verification SHALL cover: ch1 done with continue low for 5 cycles -> wait_cycles=5, FSM returns to IDLE after.
REQ-037 Verification SHALL cover: CNT_W=16, busy held 70000 cycles -> busy_cycles=65535, ovf=1.
REQ-038 Verification SHALL cover: latencies 7, 20 and 3 with HDC_PROF_MAX_LAT_EN -> max_lat=20, last_lat=3; without the macro, rd_sel=5 returns 0.
REQ-039 Verification SHALL cover: ap_rst_n pulled low mid-BUSY -> all reads return 0, any_busy=0 immediately.

Source files
------------

// File: rtl/hdc_ctrl_profiler.sv
// Per-channel ap_ctrl handshake profiler: transaction, busy, stall, wait and latency counters.
// Optional max-latency tracking is built when HDC_PROF_MAX_LAT_EN is defined.
module hdc_ctrl_profiler #(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              prof_en,
  input  logic              prof_clear,
  input  logic [NUM_CH-1:0] ch_start,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic [NUM_CH-1:0] ch_continue,
  input  logic [NUM_CH-1:0] ch_blk,
  input  logic              rd_req,
  input  logic [3:0]        rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              any_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WAIT = 2'd2
  } st_e;

  localparam logic [CNT_W-1:0] MAX = '1;

  st_e              st_q    [NUM_CH];
  st_e              st_d    [NUM_CH];
  logic [CNT_W-1:0] txn_q   [NUM_CH];
  logic [CNT_W-1:0] txn_d   [NUM_CH];
  logic [CNT_W-1:0] busy_q  [NUM_CH];
  logic [CNT_W-1:0] busy_d  [NUM_CH];
  logic [CNT_W-1:0] stall_q [NUM_CH];
  logic [CNT_W-1:0] stall_d [NUM_CH];
  logic [CNT_W-1:0] wt_q    [NUM_CH];
  logic [CNT_W-1:0] wt_d    [NUM_CH];
  logic [CNT_W-1:0] acc_q   [NUM_CH];
  logic [CNT_W-1:0] acc_d   [NUM_CH];
  logic [CNT_W-1:0] last_q  [NUM_CH];
  logic [CNT_W-1:0] last_d  [NUM_CH];
  logic             ovf_q   [NUM_CH];
  logic             ovf_d   [NUM_CH];
  logic             spur_q  [NUM_CH];
  logic             spur_d  [NUM_CH];
`ifdef HDC_PROF_MAX_LAT_EN
  logic [CNT_W-1:0] max_q   [NUM_CH];
  logic [CNT_W-1:0] max_d   [NUM_CH];
`endif

  logic             rd_valid_q;
  logic             rd_valid_d;
  logic [CNT_W-1:0] rd_data_q;
  logic [CNT_W-1:0] rd_data_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    logic             i_txn;
    logic             i_busy;
    logic             i_stall;
    logic             i_wt;
    logic             i_acc;
    logic             ld_acc;
    logic             ld_last;
    logic [CNT_W-1:0] lat;
    for (int i = 0; i < NUM_CH; i++) begin
      i_txn      = 1'b0;
      i_busy     = 1'b0;
      i_stall    = 1'b0;
      i_wt       = 1'b0;
      i_acc      = 1'b0;
      ld_acc     = 1'b0;
      ld_last    = 1'b0;
      lat        = '0;
      st_d[i]    = st_q[i];
      spur_d[i]  = spur_q[i];
      if (prof_en) begin
        unique case (st_q[i])
          S_IDLE: begin
            if (ch_start[i]) begin
              i_txn   = 1'b1;
              i_busy  = 1'b1;
              i_stall = ch_blk[i];
              ld_acc  = 1'b1;
              if (ch_done[i]) begin
                ld_last = 1'b1;
                lat     = CNT_W'(1);
                st_d[i] = ch_continue[i] ? S_IDLE : S_WAIT;
              end else begin
                st_d[i] = S_BUSY;
              end
            end else if (ch_done[i]) begin
              spur_d[i] = 1'b1;
            end
          end
          S_BUSY: begin
            i_busy  = 1'b1;
            i_stall = ch_blk[i];
            i_acc   = 1'b1;
            lat     = sat_inc(acc_q[i]);
            if (ch_done[i]) begin
              ld_last = 1'b1;
              st_d[i] = ch_continue[i] ? S_IDLE : S_WAIT;
            end
          end
          S_WAIT: begin
            i_wt = 1'b1;
            if (ch_continue[i]) st_d[i] = S_IDLE;
          end
          default: st_d[i] = S_IDLE;
        endcase
      end
      txn_d[i]   = i_txn   ? sat_inc(txn_q[i])   : txn_q[i];
      busy_d[i]  = i_busy  ? sat_inc(busy_q[i])  : busy_q[i];
      stall_d[i] = i_stall ? sat_inc(stall_q[i]) : stall_q[i];
      wt_d[i]    = i_wt    ? sat_inc(wt_q[i])    : wt_q[i];
      acc_d[i]   = ld_acc ? CNT_W'(1) : (i_acc ? lat : acc_q[i]);
      last_d[i]  = ld_last ? lat : last_q[i];
      ovf_d[i]   = ovf_q[i]
                 | (i_txn   && txn_q[i]   == MAX)
                 | (i_busy  && busy_q[i]  == MAX)
                 | (i_stall && stall_q[i] == MAX)
                 | (i_wt    && wt_q[i]    == MAX)
                 | (i_acc   && acc_q[i]   == MAX);
`ifdef HDC_PROF_MAX_LAT_EN
      max_d[i] = (ld_last && lat > max_q[i]) ? lat : max_q[i];
`endif
      // Clear wins over any counting decided above
      if (prof_clear) begin
        st_d[i]    = S_IDLE;
        txn_d[i]   = '0;
        busy_d[i]  = '0;
        stall_d[i] = '0;
        wt_d[i]    = '0;
        acc_d[i]   = '0;
        last_d[i]  = '0;
        ovf_d[i]   = 1'b0;
        spur_d[i]  = 1'b0;
`ifdef HDC_PROF_MAX_LAT_EN
        max_d[i]   = '0;
`endif
      end
    end
  end

  // Readout samples pre-update values, so a read alongside clear sees old data
  always_comb begin
    logic [CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == 4'(i)) begin
        case (rd_sel)
          3'd0: v = txn_q[i];
          3'd1: v = busy_q[i];
          3'd2: v = stall_q[i];
          3'd3: v = wt_q[i];
          3'd4: v = last_q[i];
`ifdef HDC_PROF_MAX_LAT_EN
          3'd5: v = max_q[i];
`else
          3'd5: v = '0;
`endif
          3'd6: v = {{(CNT_W-4){1'b0}}, st_q[i], ovf_q[i], spur_q[i]};
          default: v = '0;
        endcase
      end
    end
    rd_valid_d = rd_req;
    rd_data_d  = rd_req ? v : '0;
  end

  always_comb begin
    any_busy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (st_q[i] != S_IDLE) any_busy = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]    <= S_IDLE;
        txn_q[i]   <= '0;
        busy_q[i]  <= '0;
        stall_q[i] <= '0;
        wt_q[i]    <= '0;
        acc_q[i]   <= '0;
        last_q[i]  <= '0;
        ovf_q[i]   <= 1'b0;
        spur_q[i]  <= 1'b0;
`ifdef HDC_PROF_MAX_LAT_EN
        max_q[i]   <= '0;
`endif
      end
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]    <= st_d[i];
        txn_q[i]   <= txn_d[i];
        busy_q[i]  <= busy_d[i];
        stall_q[i] <= stall_d[i];
        wt_q[i]    <= wt_d[i];
        acc_q[i]   <= acc_d[i];
        last_q[i]  <= last_d[i];
        ovf_q[i]   <= ovf_d[i];
        spur_q[i]  <= spur_d[i];
`ifdef HDC_PROF_MAX_LAT_EN
        max_q[i]   <= max_d[i];
`endif
      end
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_hdc_ctrl_profiler.sv
// Randomized and directed bench for hdc_ctrl_profiler against a transaction-level model.
// Instance a uses defaults; instance b uses CNT_W=16 for saturation.
module tb_hdc_ctrl_profiler;
  localparam int NCH = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic            a_en, a_clr, a_req, a_valid, a_busy;
  logic [NCH-1:0]  a_start, a_done, a_cont, a_blk;
  logic [3:0]      a_ch;
  logic [2:0]      a_sel;
  logic [31:0]     a_data;

  logic            b_en, b_clr, b_req, b_valid, b_busy;
  logic [0:0]      b_start, b_done, b_cont, b_blk;
  logic [3:0]      b_ch;
  logic [2:0]      b_sel;
  logic [15:0]     b_data;

  int errs = 0;
  int checks = 0;

  longint m_txn[NCH], m_busy[NCH], m_stall[NCH], m_wt[NCH];
  longint m_last[NCH], m_max[NCH];
  bit     m_spur[NCH];

  hdc_ctrl_profiler #(.NUM_CH(NCH), .CNT_W(32)) u_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .prof_en(a_en), .prof_clear(a_clr),
    .ch_start(a_start), .ch_done(a_done), .ch_continue(a_cont), .ch_blk(a_blk),
    .rd_req(a_req), .rd_ch(a_ch), .rd_sel(a_sel),
    .rd_valid(a_valid), .rd_data(a_data), .any_busy(a_busy));

  hdc_ctrl_profiler #(.NUM_CH(1), .CNT_W(16)) u_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .prof_en(b_en), .prof_clear(b_clr),
    .ch_start(b_start), .ch_done(b_done), .ch_continue(b_cont), .ch_blk(b_blk),
    .rd_req(b_req), .rd_ch(b_ch), .rd_sel(b_sel),
    .rd_valid(b_valid), .rd_data(b_data), .any_busy(b_busy));

  function automatic void model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_txn[i] = 0; m_busy[i] = 0; m_stall[i] = 0; m_wt[i] = 0;
      m_last[i] = 0; m_max[i] = 0; m_spur[i] = 0;
    end
  endfunction

  // One completed transaction: L cycles from start to done inclusive, W cycles awaiting continue
  function automatic void model_txn(int ch, int lat, int ns, int w);
    m_txn[ch]   += 1;
    m_busy[ch]  += lat;
    m_stall[ch] += ns;
    m_wt[ch]    += w;
    m_last[ch]   = lat;
    if (lat > m_max[ch]) m_max[ch] = lat;
  endfunction

  function automatic longint expv(int ch, int sel);
    case (sel)
      0: return m_txn[ch];
      1: return m_busy[ch];
      2: return m_stall[ch];
      3: return m_wt[ch];
      4: return m_last[ch];
`ifdef HDC_PROF_MAX_LAT_EN
      5: return m_max[ch];
`endif
      6: return m_spur[ch] ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic rd_a(input int ch, input int sel,
                      output logic v, output logic [31:0] d);
    a_req = 1'b1; a_ch = 4'(ch); a_sel = 3'(sel);
    @(negedge clk);
    v = a_valid; d = a_data;
    a_req = 1'b0;
  endtask

  task automatic rd_b(input int sel, output logic v, output logic [15:0] d);
    b_req = 1'b1; b_ch = 4'd0; b_sel = 3'(sel);
    @(negedge clk);
    v = b_valid; d = b_data;
    b_req = 1'b0;
  endtask

  task automatic run_txn(input int ch, input int lat, input int w,
                         input logic [31:0] blkm);
    int ns;
    ns = 0;
    for (int k = 0; k < lat; k++) begin
      a_start[ch] = (k == 0);
      a_done[ch]  = (k == lat - 1);
      a_blk[ch]   = blkm[k];
      a_cont[ch]  = (k == lat - 1) ? (w == 0) : 1'b1;
      if (blkm[k]) ns++;
      @(negedge clk);
    end
    a_start[ch] = 1'b0; a_done[ch] = 1'b0; a_blk[ch] = 1'b0;
    for (int k = 0; k < w; k++) begin
      a_cont[ch] = (k == w - 1);
      @(negedge clk);
    end
    a_cont[ch] = 1'b1;
    model_txn(ch, lat, ns, w);
  endtask

  task automatic test_reset();
    logic v; logic [31:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_valid !== 1'b0 || a_data !== 32'd0 || a_busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_outs valid=%b data=%0d busy=%b want 0", a_valid, a_data, a_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    model_clear();
    for (int s = 0; s < 7; s++) begin
      rd_a(0, s, v, d);
      checks++;
      if (v !== 1'b1 || d !== 32'd0) begin
        errs++;
        $display("FAIL reset_read sel=%0d valid=%b data=%0d want 1/0", s, v, d);
      end
    end
  endtask

  task automatic test_basic();
    logic v; logic [31:0] d;
    run_txn(0, 10, 0, 32'd0);
    rd_a(0, 0, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'd1) begin
      errs++; $display("FAIL basic_txn got %0d want 1", d);
    end
    rd_a(0, 1, v, d);
    checks++;
    if (d !== 32'd10) begin errs++; $display("FAIL basic_busy got %0d want 10", d); end
    rd_a(0, 4, v, d);
    checks++;
    if (d !== 32'd10) begin errs++; $display("FAIL basic_last got %0d want 10", d); end
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b0 || a_data !== 32'd0) begin
      errs++; $display("FAIL rd_idle valid=%b data=%0d want 0/0", a_valid, a_data);
    end
  endtask

  task automatic test_stall();
    logic v; logic [31:0] d;
    run_txn(2, 12, 0, 32'h0000_0A50);
    rd_a(2, 2, v, d);
    checks++;
    if (d !== 32'd4) begin errs++; $display("FAIL stall_cnt got %0d want 4", d); end
    rd_a(2, 1, v, d);
    checks++;
    if (d !== 32'd12) begin errs++; $display("FAIL stall_busy got %0d want 12", d); end
  endtask

  task automatic test_wait();
    logic v; logic [31:0] d;
    run_txn(1, 3, 5, 32'd0);
    rd_a(1, 3, v, d);
    checks++;
    if (d !== 32'd5) begin errs++; $display("FAIL wait_cnt got %0d want 5", d); end
    rd_a(1, 6, v, d);
    checks++;
    if (d !== 32'd0) begin errs++; $display("FAIL wait_state got %0d want 0", d); end
    checks++;
    if (a_busy !== 1'b0) begin errs++; $display("FAIL wait_anybusy got %b want 0", a_busy); end
  endtask

  task automatic test_spurious();
    logic v; logic [31:0] d;
    a_done[4] = 1'b1;
    @(negedge clk);
    a_done[4] = 1'b0;
    m_spur[4] = 1'b1;
    rd_a(4, 6, v, d);
    checks++;
    if (d !== 32'd1) begin errs++; $display("FAIL spur_flag got %0d want 1", d); end
    rd_a(4, 0, v, d);
    checks++;
    if (d !== 32'd0) begin errs++; $display("FAIL spur_txn got %0d want 0", d); end
  endtask

  task automatic test_range();
    logic v; logic [31:0] d;
    rd_a(6, 0, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'd0) begin
      errs++; $display("FAIL range_ch6 valid=%b data=%0d want 1/0", v, d);
    end
    rd_a(15, 1, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'd0) begin
      errs++; $display("FAIL range_ch15 valid=%b data=%0d want 1/0", v, d);
    end
    rd_a(0, 7, v, d);
    checks++;
    if (d !== 32'd0) begin errs++; $display("FAIL sel7 got %0d want 0", d); end
  endtask

  task automatic test_freeze();
    logic v; logic [31:0] d;
    a_start[5] = 1'b1;
    @(negedge clk);
    a_start[5] = 1'b0;
    repeat (2) @(negedge clk);
    a_en = 1'b0; a_blk[5] = 1'b1; a_done[5] = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (a_busy !== 1'b1) begin errs++; $display("FAIL freeze_anybusy got %b want 1", a_busy); end
    rd_a(5, 6, v, d);
    checks++;
    if (d !== 32'd4) begin errs++; $display("FAIL freeze_state got %0d want 4", d); end
    a_en = 1'b1; a_blk[5] = 1'b0; a_done[5] = 1'b0;
    repeat (2) @(negedge clk);
    a_done[5] = 1'b1;
    @(negedge clk);
    a_done[5] = 1'b0;
    model_txn(5, 6, 0, 0);
    rd_a(5, 1, v, d);
    checks++;
    if (d !== 32'd6) begin errs++; $display("FAIL freeze_busy got %0d want 6", d); end
    rd_a(5, 4, v, d);
    checks++;
    if (d !== 32'd6) begin errs++; $display("FAIL freeze_last got %0d want 6", d); end
    rd_a(5, 2, v, d);
    checks++;
    if (d !== 32'd0) begin errs++; $display("FAIL freeze_stall got %0d want 0", d); end
  endtask

  task automatic test_clear();
    logic v; logic [31:0] d;
    a_clr = 1'b1;
    rd_a(0, 1, v, d);
    a_clr = 1'b0;
    checks++;
    if (d !== 32'd10) begin errs++; $display("FAIL clear_preval got %0d want 10", d); end
    model_clear();
    rd_a(0, 1, v, d);
    checks++;
    if (d !== 32'd0) begin errs++; $display("FAIL clear_busy got %0d want 0", d); end
    rd_a(4, 6, v, d);
    checks++;
    if (d !== 32'd0) begin errs++; $display("FAIL clear_flag got %0d want 0", d); end
  endtask

  task automatic test_maxlat();
    logic v; logic [31:0] d;
    longint want;
    run_txn(3, 7, 0, 32'd0);
    run_txn(3, 20, 1, 32'd0);
    run_txn(3, 3, 0, 32'd0);
`ifdef HDC_PROF_MAX_LAT_EN
    want = 20;
`else
    want = 0;
`endif
    rd_a(3, 5, v, d);
    checks++;
    if (d !== 32'(want)) begin errs++; $display("FAIL max_lat got %0d want %0d", d, want); end
    rd_a(3, 4, v, d);
    checks++;
    if (d !== 32'd3) begin errs++; $display("FAIL max_last got %0d want 3", d); end
  endtask

  task automatic test_random();
    logic v; logic [31:0] d;
    for (int n = 0; n < 30; n++) begin
      run_txn(int'($urandom_range(0, NCH - 1)), int'($urandom_range(1, 25)),
              int'($urandom_range(0, 4)), $urandom);
    end
    for (int c = 0; c < NCH; c++) begin
      for (int s = 0; s < 7; s++) begin
        rd_a(c, s, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'(expv(c, s))) begin
          errs++;
          $display("FAIL rand ch=%0d sel=%0d valid=%b got %0d want %0d",
                   c, s, v, d, expv(c, s));
        end
      end
    end
  endtask

  task automatic test_saturate();
    logic v; logic [15:0] d;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    repeat (70000) @(negedge clk);
    rd_b(1, v, d);
    checks++;
    if (d !== 16'hFFFF) begin errs++; $display("FAIL sat_busy got %0d want 65535", d); end
    rd_b(6, v, d);
    checks++;
    if (d !== 16'd6) begin errs++; $display("FAIL sat_status got %0d want 6", d); end
    rd_b(0, v, d);
    checks++;
    if (d !== 16'd1) begin errs++; $display("FAIL sat_txn got %0d want 1", d); end
  endtask

  task automatic test_reset_mid();
    logic v; logic [31:0] d;
    a_start[0] = 1'b1;
    @(negedge clk);
    a_start[0] = 1'b0;
    a_req = 1'b1; a_ch = 4'd0; a_sel = 3'd1;
    @(negedge clk);
    a_req = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || b_busy !== 1'b1 || a_valid !== 1'b1) begin
      errs++; $display("FAIL pre_rst busy=%b/%b valid=%b want 1", a_busy, b_busy, a_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0 || a_valid !== 1'b0 || a_data !== 32'd0) begin
      errs++;
      $display("FAIL rst_mid busy=%b/%b valid=%b data=%0d want 0", a_busy, b_busy, a_valid, a_data);
    end
    @(negedge clk);
    model_clear();
    rst_n = 1'b1;
    a_start[0] = 1'b1;
    @(negedge clk);
    a_start[0] = 1'b0;
    a_done[0] = 1'b1;
    @(negedge clk);
    a_done[0] = 1'b0;
    model_txn(0, 2, 0, 0);
    rd_a(0, 0, v, d);
    checks++;
    if (d !== 32'(expv(0, 0))) begin errs++; $display("FAIL post_rst_txn got %0d want 1", d); end
    rd_a(0, 1, v, d);
    checks++;
    if (d !== 32'(expv(0, 1))) begin errs++; $display("FAIL post_rst_busy got %0d want 2", d); end
    for (int s = 0; s < 7; s++) begin
      rd_a(3, s, v, d);
      checks++;
      if (d !== 32'd0) begin errs++; $display("FAIL post_rst_ch3 sel=%0d got %0d want 0", s, d); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 1'b1; a_clr = 1'b0; a_req = 1'b0; a_ch = '0; a_sel = '0;
    a_start = '0; a_done = '0; a_cont = '1; a_blk = '0;
    b_en = 1'b1; b_clr = 1'b0; b_req = 1'b0; b_ch = '0; b_sel = '0;
    b_start = '0; b_done = '0; b_cont = '1; b_blk = '0;
    model_clear();
    test_reset();
    test_basic();
    test_stall();
    test_wait();
    test_spurious();
    test_range();
    test_freeze();
    test_clear();
    test_maxlat();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
